// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle core sequencer: default parameters,
// FSM state encoding, opcode and instruction constants.
package core_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 255;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALTED,
    ST_FAULT
  } state_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Loads and stores are the only instructions that visit MEM.
  function automatic logic is_mem_op(input logic [31:0] instr);
    return (instr[6:0] == OPCODE_LOAD) || (instr[6:0] == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory ports (slave).
interface core_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    output dmem_req,
    input  imem_ready,
    input  imem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  dmem_req,
    output imem_ready,
    output imem_rdata,
    output dmem_ready
  );

endinterface

// File: rtl/core_sequencer_wait_timer.sv
// Wait-state timer shared by FETCH and MEM. expired rises in the waiting
// cycle whose increment would bring the count to TIMEOUT, so the caller can
// leave for FAULT on that same edge.
module core_sequencer_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned     W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]    LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Counter: clear on state change, otherwise advance while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = count && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: owns the PC, fetches over the imem handshake, holds
// the instruction for the datapath, waits on dmem for loads/stores and
// issues a single-cycle commit strobe in WRITEBACK.
// Optional feature macro: HALT_ON_EBREAK_EN (EBREAK halts in EXECUTE).
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  core_sequencer_if.master        bus,
  output logic [31:0]             instruction,
  output logic [31:0]             pc,
  output logic [31:0]             pc_next,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  output logic                    commit,
  output logic                    halted,
  output logic                    fault
);

  state_t state;
  state_t state_next;

  logic timer_count;
  logic timer_clear;
  logic timer_expired;
  logic redirect_bad;
  logic ebreak_halt;

  core_sequencer_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  assign pc_next       = pc + 32'd4;
  assign bus.imem_addr = pc;
  assign redirect_bad  = branch_taken && (branch_target[1:0] != 2'b00);

`ifdef HALT_ON_EBREAK_EN
  assign ebreak_halt = (instruction == INSTR_EBREAK);
  assign halted      = (state == ST_HALTED);
`else
  assign ebreak_halt = 1'b0;
  assign halted      = 1'b0;
`endif

  assign fault = (state == ST_FAULT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, strobes and timer control; ready beats timeout.
  always_comb begin
    state_next   = state;
    commit       = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    timer_count  = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          state_next = ST_EXECUTE;
        end else begin
          timer_count = 1'b1;
          if (timer_expired) state_next = ST_FAULT;
        end
      end
      ST_EXECUTE: begin
        if (ebreak_halt)                 state_next = ST_HALTED;
        else if (is_mem_op(instruction)) state_next = ST_MEM;
        else                             state_next = ST_WRITEBACK;
      end
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          state_next = ST_WRITEBACK;
        end else begin
          timer_count = 1'b1;
          if (timer_expired) state_next = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        if (redirect_bad) begin
          state_next = ST_FAULT;
        end else begin
          commit     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_FAULT;
    endcase
    timer_clear = (state_next != state);
  end

  // Instruction latch on fetch handshake; PC update only on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instruction <= INSTR_NOP;
    end else begin
      if ((state == ST_FETCH) && bus.imem_ready) begin
        instruction <= bus.imem_rdata;
      end
      if (commit) begin
        pc <= branch_taken ? branch_target : pc_next;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a responder issues randomized
// instructions/wait states and queues the expected commit; a monitor pops
// and compares on every commit. Directed cases cover faults and reset.
module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam int          TO     = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction, pc, pc_next;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        commit, halted, fault;

  core_sequencer_if ifc();

  core_sequencer #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (ifc),
    .instruction   (instruction),
    .pc            (pc),
    .pc_next       (pc_next),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .commit        (commit),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          lat;
    int          dcyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected handshake within bound at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_imem_req();
    int n;
    n = 0;
    while (!ifc.imem_req && n < 40) begin step(); n++; end
    if (!ifc.imem_req) bound_fail("imem_req_wait");
  endtask

  task automatic wait_dmem_req();
    int n;
    n = 0;
    while (!ifc.dmem_req && n < 40) begin step(); n++; end
    if (!ifc.dmem_req) bound_fail("dmem_req_wait");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.imem_ready = 1'b0;
    ifc.dmem_ready = 1'b0;
    branch_taken   = 1'b0;
    step();
    step();
    chk("rst_pc", pc, RST_PC);
    chk("rst_imem_addr", ifc.imem_addr, RST_PC);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_commit", {31'b0, commit}, 32'd0);
    chk("rst_dmem_req", {31'b0, ifc.dmem_req}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    reset    = 1'b0;
    model_pc = RST_PC;
  endtask

  // Serve one instruction: wi imem wait cycles, wd dmem wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int wi, input int wd,
                           input logic bt, input logic [31:0] tgt, input bit expect_commit);
    bit   is_mem;
    exp_t e;
    is_mem = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
    wait_imem_req();
    branch_taken  = bt;
    branch_target = tgt;
    chk("imem_addr", ifc.imem_addr, model_pc);
    if (expect_commit) begin
      e.pc    = model_pc;
      e.instr = ins;
      e.dcyc  = is_mem ? wd + 1 : 0;
      e.lat   = 3 + wi + e.dcyc;
      sb.push_back(e);
      model_pc = bt ? tgt : model_pc + 32'd4;
    end
    for (int k = 0; k < wi; k++) begin
      ifc.imem_ready = 1'b0;
      ifc.imem_rdata = $urandom;
      ifc.dmem_ready = 1'($urandom_range(0, 1));
      step();
    end
    ifc.imem_ready = 1'b1;
    ifc.imem_rdata = ins;
    ifc.dmem_ready = 1'b0;
    step();
    ifc.imem_ready = 1'b0;
    ifc.imem_rdata = $urandom;
    if (is_mem) begin
      wait_dmem_req();
      for (int k = 0; k < wd; k++) begin
        ifc.dmem_ready = 1'b0;
        ifc.imem_ready = 1'($urandom_range(0, 1));
        ifc.imem_rdata = $urandom;
        step();
      end
      ifc.dmem_ready = 1'b1;
      ifc.imem_ready = 1'b0;
      step();
      ifc.dmem_ready = 1'b0;
    end
  endtask

  // Monitor: on every commit pop the oldest expectation and compare.
  initial begin
    int   lat;
    int   dc;
    logic prev;
    exp_t e;
    lat  = 0;
    dc   = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lat  = 0;
        dc   = 0;
        prev = 1'b0;
      end else begin
        lat++;
        if (ifc.dmem_req) dc++;
        if (commit) begin
          chk("commit_back_to_back", {31'b0, prev}, 32'd0);
          if (sb.size() == 0) begin
            bound_fail("unexpected_commit");
          end else begin
            e = sb.pop_front();
            chk("commit_pc", pc, e.pc);
            chk("commit_instr", instruction, e.instr);
            chk("commit_pc_next", pc_next, e.pc + 32'd4);
            chk("latency", 32'(lat), 32'(e.lat));
            chk("dmem_req_cycles", 32'(dc), 32'(e.dcyc));
          end
          lat = 0;
          dc  = 0;
        end
        prev = commit;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, tgt;
    logic        bt;
    int          sel, n;
    ifc.imem_ready = 1'b0;
    ifc.imem_rdata = '0;
    ifc.dmem_ready = 1'b0;
    do_reset();

    // Zero-wait ALU instruction, stability through EXECUTE and WRITEBACK.
    run_instr(32'h0050_0093, 0, 0, 1'b0, '0, 1'b1);
    chk("exec_instr", instruction, 32'h0050_0093);
    chk("exec_commit", {31'b0, commit}, 32'd0);
    step();
    chk("wb_commit", {31'b0, commit}, 32'd1);
    chk("wb_instr", instruction, 32'h0050_0093);
    step();
    chk("pc_after_addi", pc, RST_PC + 32'd4);

    run_instr(32'h0000_2103, 2, 3, 1'b0, '0, 1'b1);
    run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0100, 1'b1);
    run_instr(32'h0050_0093, 1, 0, 1'b0, '0, 1'b1);
    run_instr(32'h0000_006f, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run_instr(32'h0000_0013, 0, 0, 1'b0, '0, 1'b1);
    run_instr(32'h00a0_0093, TO - 1, 0, 1'b0, '0, 1'b1);
    run_instr(32'h0011_2023, 0, TO - 1, 1'b0, '0, 1'b1);
`ifndef HALT_ON_EBREAK_EN
    run_instr(32'h0010_0073, 0, 0, 1'b0, '0, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      ins = $urandom;
      case (sel)
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2: ins[6:0] = 7'h13;
        3: ins[6:0] = 7'h33;
        4: ins[6:0] = 7'h63;
`ifdef HALT_ON_EBREAK_EN
        default: ins[6:0] = 7'h37;
`else
        default: ins = 32'h0010_0073;
`endif
      endcase
      tgt      = $urandom;
      tgt[1:0] = 2'b00;
      bt       = ($urandom_range(0, 3) == 0);
      run_instr(ins, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), bt, tgt, 1'b1);
    end
    repeat (6) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Misaligned redirect: fault, no commit, pc frozen.
    run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0102, 1'b0);
    step();
    chk("misaligned_wb_commit", {31'b0, commit}, 32'd0);
    step();
    chk("misaligned_fault", {31'b0, fault}, 32'd1);
    chk("misaligned_pc", pc, model_pc);
    chk("misaligned_imem_req", {31'b0, ifc.imem_req}, 32'd0);
    repeat (3) step();
    chk("fault_sticky", {31'b0, fault}, 32'd1);

    // Fetch timeout.
    do_reset();
    n = 0;
    while (ifc.imem_req && n < 20) begin n++; step(); end
    chk("timeout_fetch_cycles", 32'(n), 32'(TO));
    chk("timeout_fault", {31'b0, fault}, 32'd1);
    repeat (3) step();
    chk("timeout_fault_sticky", {31'b0, fault}, 32'd1);
    chk("timeout_imem_req", {31'b0, ifc.imem_req}, 32'd0);
    chk("timeout_pc", pc, RST_PC);

    // Reset asserted while a load waits in MEM.
    do_reset();
    run_instr(32'h0050_0093, 0, 0, 1'b0, '0, 1'b1);
    run_instr(32'h0010_0113, 1, 0, 1'b0, '0, 1'b1);
    wait_imem_req();
    chk("mem_reset_fetch_addr", ifc.imem_addr, model_pc);
    ifc.imem_ready = 1'b1;
    ifc.imem_rdata = 32'h0000_2103;
    step();
    ifc.imem_ready = 1'b0;
    wait_dmem_req();
    step();
    step();
    chk("mem_reset_pc_before", pc, RST_PC + 32'd8);
    #2;
    reset = 1'b1;
    #1;
    chk("mem_reset_pc", pc, RST_PC);
    chk("mem_reset_instr", instruction, 32'h0000_0013);
    chk("mem_reset_commit", {31'b0, commit}, 32'd0);
    chk("mem_reset_dmem_req", {31'b0, ifc.dmem_req}, 32'd0);
    do_reset();

`ifdef HALT_ON_EBREAK_EN
    run_instr(32'h0010_0073, 0, 0, 1'b0, '0, 1'b0);
    chk("ebreak_exec_halted", {31'b0, halted}, 32'd0);
    step();
    chk("ebreak_halted", {31'b0, halted}, 32'd1);
    chk("ebreak_commit", {31'b0, commit}, 32'd0);
    chk("ebreak_pc", pc, model_pc);
    repeat (3) step();
    chk("ebreak_halted_sticky", {31'b0, halted}, 32'd1);
    chk("ebreak_imem_req", {31'b0, ifc.imem_req}, 32'd0);
`endif

    repeat (2) step();
    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
